rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two requesters:
  - the in-order pipeline writeback stage (ws)
  - the out-of-band long-latency multiply/divide unit (mdu)
- Tracks pending mdu destinations in a scoreboard so decode can stall on RAW/WAW against in-flight mdu results.
- Sits between wb stage / mdu and the regfile; drives the rf write bus and trace debug outputs.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback path: the packed rf write bus
// {we, waddr, wdata} and the general-register count.
package rf_wb_arbiter_pkg;

    localparam int GR_NUM       = 32;
    localparam int RF_WB_BUS_WD = 38;

    typedef logic [RF_WB_BUS_WD-1:0] rf_wb_bus_t;

    function automatic rf_wb_bus_t pack_wb(input logic we, input logic [4:0] waddr,
                                           input logic [31:0] wdata);
        return {we, waddr, wdata};
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination vector for in-flight mdu results, with issue gating and
// the three-port decode lookup. Register 0 is never tracked.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    output logic              issue_ready,
    input  logic              clr_en,
    input  logic [4:0]        clr_idx,
    input  logic [4:0]        rj,
    input  logic [4:0]        rk,
    input  logic [4:0]        rd,
    output logic              hit,
    output logic [GR_NUM-1:0] pending
);

    logic [GR_NUM-1:0] sb_q;
    logic [GR_NUM-1:0] sb_d;
    logic              set_en;

    assign issue_ready = !sb_q[issue_dest] || (issue_dest == 5'd0);
    assign set_en      = issue_valid && issue_ready && (issue_dest != 5'd0);
    assign hit         = sb_q[rj] || sb_q[rk] || sb_q[rd];
    assign pending     = sb_q;

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_idx] = 1'b0;
        if (set_en) sb_d[issue_dest] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) sb_q <= '0;
        else       sb_q <= sb_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between the writeback stage and the
// mdu, with starvation forcing and a registered rf/debug bus. Optional perf
// counters are enabled by defining RF_WB_ARB_PERF_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_wb_valid,
    input  logic        ws_wb_we,
    input  logic [4:0]  ws_wb_dest,
    input  logic [31:0] ws_wb_wdata,
    input  logic [31:0] ws_wb_pc,
    output logic        ws_wb_ready,
    input  logic        mdu_wb_valid,
    input  logic [4:0]  mdu_wb_dest,
    input  logic [31:0] mdu_wb_wdata,
    input  logic [31:0] mdu_wb_pc,
    output logic        mdu_wb_ready,
    input  logic        mdu_issue_valid,
    input  logic [4:0]  mdu_issue_dest,
    output logic        mdu_issue_ready,
    input  logic [4:0]  ds_rj,
    input  logic [4:0]  ds_rk,
    input  logic [4:0]  ds_rd,
    output logic        ds_sb_hit,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_force_cnt
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              ws_need;
    logic              mdu_need;
    logic              both_need;
    logic              force_mdu;
    logic              ws_write;
    logic              mdu_fire;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    rf_wb_bus_t        bus_q;
    rf_wb_bus_t        bus_d;
    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic [GR_NUM-1:0] sb_pending;

    always_comb begin
        ws_need      = ws_wb_valid && ws_wb_we && (ws_wb_dest != 5'd0);
        mdu_need     = mdu_wb_valid && (mdu_wb_dest != 5'd0);
        both_need    = ws_need && mdu_need;
        force_mdu    = both_need && (starve_q == LIMIT);
        ws_wb_ready  = !force_mdu;
        mdu_wb_ready = !both_need || force_mdu;
        ws_write     = ws_need && !force_mdu;
        mdu_fire     = mdu_wb_valid && mdu_wb_ready;

        starve_d = starve_q;
        if (mdu_fire)
            starve_d = '0;
        else if (mdu_wb_valid && (starve_q < LIMIT))
            starve_d = starve_q + CNT_W'(1);

        // Address/data hold when the port is idle; only the enable drops.
        bus_d                 = bus_q;
        bus_d[RF_WB_BUS_WD-1] = 1'b0;
        pc_d                  = pc_q;
        if (ws_write) begin
            bus_d = pack_wb(1'b1, ws_wb_dest, ws_wb_wdata);
            pc_d  = ws_wb_pc;
        end else if (mdu_fire) begin
            bus_d = pack_wb(mdu_need, mdu_wb_dest, mdu_wb_wdata);
            pc_d  = mdu_wb_pc;
        end else if (ws_wb_valid) begin
            pc_d  = ws_wb_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            bus_q    <= '0;
            pc_q     <= '0;
        end else begin
            starve_q <= starve_d;
            bus_q    <= bus_d;
            pc_q     <= pc_d;
        end
    end

    // Decode stalls on ds_rd, so ws must never target a pending mdu destination.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(ws_need && sb_pending[ws_wb_dest]));
    end

    rf_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (mdu_issue_valid),
        .issue_dest  (mdu_issue_dest),
        .issue_ready (mdu_issue_ready),
        .clr_en      (mdu_fire && mdu_need),
        .clr_idx     (mdu_wb_dest),
        .rj          (ds_rj),
        .rk          (ds_rk),
        .rd          (ds_rd),
        .hit         (ds_sb_hit),
        .pending     (sb_pending)
    );

    assign rf_we             = bus_q[RF_WB_BUS_WD-1];
    assign rf_waddr          = bus_q[36:32];
    assign rf_wdata          = bus_q[31:0];
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dbg_we
        assign debug_wb_rf_we[gi] = rf_we;
    end

`ifdef RF_WB_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic [31:0] force_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
            force_q    <= '0;
        end else begin
            if (both_need) conflict_q <= conflict_q + 32'd1;
            if (force_mdu) force_q    <= force_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_force_cnt    = force_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter against a cycle-level behavioural model,
// preceded by short directed scenarios.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_wb_valid, ws_wb_we;
    logic [4:0]  ws_wb_dest;
    logic [31:0] ws_wb_wdata, ws_wb_pc;
    logic        ws_wb_ready;
    logic        mdu_wb_valid;
    logic [4:0]  mdu_wb_dest;
    logic [31:0] mdu_wb_wdata, mdu_wb_pc;
    logic        mdu_wb_ready;
    logic        mdu_issue_valid;
    logic [4:0]  mdu_issue_dest;
    logic        mdu_issue_ready;
    logic [4:0]  ds_rj, ds_rk, ds_rd;
    logic        ds_sb_hit;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .ws_wb_valid(ws_wb_valid), .ws_wb_we(ws_wb_we), .ws_wb_dest(ws_wb_dest),
        .ws_wb_wdata(ws_wb_wdata), .ws_wb_pc(ws_wb_pc), .ws_wb_ready(ws_wb_ready),
        .mdu_wb_valid(mdu_wb_valid), .mdu_wb_dest(mdu_wb_dest),
        .mdu_wb_wdata(mdu_wb_wdata), .mdu_wb_pc(mdu_wb_pc), .mdu_wb_ready(mdu_wb_ready),
        .mdu_issue_valid(mdu_issue_valid), .mdu_issue_dest(mdu_issue_dest),
        .mdu_issue_ready(mdu_issue_ready),
        .ds_rj(ds_rj), .ds_rk(ds_rk), .ds_rd(ds_rd), .ds_sb_hit(ds_sb_hit),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: pending set, starvation age, and the last rf bus.
    bit [31:0] m_sb;
    int        m_starve;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata, m_pc;
    logic      obs_ws_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        reset = 1'b0;
        ws_wb_valid = 1'b0; ws_wb_we = 1'b0; ws_wb_dest = '0; ws_wb_wdata = '0; ws_wb_pc = '0;
        mdu_wb_valid = 1'b0; mdu_wb_dest = '0; mdu_wb_wdata = '0; mdu_wb_pc = '0;
        mdu_issue_valid = 1'b0; mdu_issue_dest = '0;
        ds_rj = '0; ds_rk = '0; ds_rd = '0;
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        bit ws_need, md_need, forced, exp_ws_rdy, exp_mdu_rdy, mdu_acc, iss_acc;
        string owner;
        #1;
        ws_need = ws_wb_valid && ws_wb_we && (ws_wb_dest != 0);
        md_need = mdu_wb_valid && (mdu_wb_dest != 0);
        forced  = ws_need && md_need && (m_starve == 4);
        exp_ws_rdy  = !forced;
        exp_mdu_rdy = !(ws_need && md_need && !forced);
        mdu_acc = mdu_wb_valid && exp_mdu_rdy;
        iss_acc = mdu_issue_valid && (mdu_issue_dest == 0 || !m_sb[mdu_issue_dest]);

        check_eq("ws_wb_ready", ws_wb_ready, exp_ws_rdy);
        check_eq("mdu_wb_ready", mdu_wb_ready, exp_mdu_rdy);
        check_eq("mdu_issue_ready", mdu_issue_ready,
                 mdu_issue_dest == 0 || !m_sb[mdu_issue_dest]);
        check_eq("ds_sb_hit", ds_sb_hit, m_sb[ds_rj] | m_sb[ds_rk] | m_sb[ds_rd]);
        check_eq("rf_we", rf_we, m_we);
        check_eq("rf_waddr", rf_waddr, m_waddr);
        check_eq("rf_wdata", rf_wdata, m_wdata);
        check_eq("debug_wb_pc", debug_wb_pc, m_pc);
        check_eq("debug_wb_rf_we", debug_wb_rf_we, {4{m_we}});
        check_eq("debug_wb_rf_wnum", debug_wb_rf_wnum, m_waddr);
        check_eq("debug_wb_rf_wdata", debug_wb_rf_wdata, m_wdata);
        obs_ws_rdy = ws_wb_ready;

        owner = "none";
        if (ws_need && !forced) owner = "ws";
        else if (mdu_acc)       owner = "mdu";

        @(posedge clk);
        if (reset) begin
            m_sb = 0; m_starve = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
        end else begin
            if (mdu_acc)                m_starve = 0;
            else if (mdu_wb_valid)      m_starve = (m_starve < 4) ? m_starve + 1 : 4;
            if (mdu_acc && md_need)     m_sb[mdu_wb_dest] = 1'b0;
            if (iss_acc && mdu_issue_dest != 0) m_sb[mdu_issue_dest] = 1'b1;
            m_we = 0;
            if (owner == "ws") begin
                m_we = 1; m_waddr = ws_wb_dest; m_wdata = ws_wb_wdata; m_pc = ws_wb_pc;
            end else if (owner == "mdu") begin
                m_we = md_need; m_waddr = mdu_wb_dest; m_wdata = mdu_wb_wdata; m_pc = mdu_wb_pc;
            end else if (ws_wb_valid) begin
                m_pc = ws_wb_pc;
            end
            if (owner != "none")
                $display("txn t=%0t owner=%s dest=%0d data=%08h pc=%08h",
                         $time, owner, m_waddr, m_wdata, m_pc);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        set_idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] rdy_seen;
        set_idle();
        reset = 1'b1;
        m_sb = 0; m_starve = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: lone ws write
        ws_wb_valid = 1; ws_wb_we = 1; ws_wb_dest = 5; ws_wb_wdata = 32'h1234; ws_wb_pc = 32'h100;
        cycle();
        set_idle();
        #1;
        check_eq("t1_rf_we", rf_we, 1);
        check_eq("t1_rf_waddr", rf_waddr, 5);
        check_eq("t1_rf_wdata", rf_wdata, 32'h1234);
        cycle();

        // 2: issue dest 7, observe hit, retire it, hit drops
        mdu_issue_valid = 1; mdu_issue_dest = 7;
        cycle();
        set_idle(); ds_rj = 7;
        #1 check_eq("t2_hit_set", ds_sb_hit, 1);
        mdu_wb_valid = 1; mdu_wb_dest = 7; mdu_wb_wdata = 32'hbeef; mdu_wb_pc = 32'h200;
        cycle();
        set_idle(); ds_rj = 7;
        #1 check_eq("t2_hit_clr", ds_sb_hit, 0);
        cycle();

        // 3: six cycles of contention; only cycle 4 goes to the mdu
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            ws_wb_valid = 1; ws_wb_we = 1; ws_wb_dest = 10; ws_wb_wdata = 32'(i); ws_wb_pc = 32'h300 + 32'(i);
            mdu_wb_valid = 1; mdu_wb_dest = 11; mdu_wb_wdata = 32'hd00d; mdu_wb_pc = 32'h400;
            cycle();
            rdy_seen[i] = obs_ws_rdy;
        end
        check_eq("t3_ws_ready_pattern", {26'd0, rdy_seen}, 32'b10_1111);

        // 4: ws retires without a write, mdu dest 9 takes the port
        set_idle();
        ws_wb_valid = 1; ws_wb_we = 0; ws_wb_dest = 2; ws_wb_pc = 32'h500;
        mdu_wb_valid = 1; mdu_wb_dest = 9; mdu_wb_wdata = 32'h99; mdu_wb_pc = 32'h600;
        #1;
        check_eq("t4_ws_ready", ws_wb_ready, 1);
        check_eq("t4_mdu_ready", mdu_wb_ready, 1);
        cycle();
        set_idle();
        #1 check_eq("t4_rf_waddr", rf_waddr, 9);

        // 5: blocked reissue, then set beats clear on the same register
        pulse_reset();
        mdu_issue_valid = 1; mdu_issue_dest = 3;
        cycle();
        #1 check_eq("t5_issue_blocked", mdu_issue_ready, 0);
        cycle();
        set_idle(); mdu_wb_valid = 1; mdu_wb_dest = 3; mdu_wb_wdata = 32'h33;
        cycle();
        mdu_issue_valid = 1; mdu_issue_dest = 3;
        cycle();
        set_idle(); ds_rk = 3;
        #1 check_eq("t5_set_wins", ds_sb_hit, 1);
        cycle();

        // 6: reset with sb=0x88 and a grant in flight
        pulse_reset();
        mdu_issue_valid = 1; mdu_issue_dest = 3; cycle();
        mdu_issue_dest = 7; cycle();
        set_idle();
        mdu_wb_valid = 1; mdu_wb_dest = 7; mdu_wb_wdata = 32'h77; reset = 1;
        cycle();
        set_idle(); ds_rj = 3; ds_rk = 7; mdu_issue_dest = 3;
        #1;
        check_eq("t6_rf_we", rf_we, 0);
        check_eq("t6_hit", ds_sb_hit, 0);
        check_eq("t6_issue_ready", mdu_issue_ready, 1);
        cycle();

        // Randomized traffic checked against the model
        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(99) == 0);
            ws_wb_valid     = 1'($urandom_range(1));
            ws_wb_we        = 1'($urandom_range(1));
            ws_wb_dest      = 5'($urandom_range(31));
            if (m_sb[ws_wb_dest]) ws_wb_we = 1'b0;
            ws_wb_wdata     = $urandom;
            ws_wb_pc        = $urandom;
            mdu_wb_valid    = 1'($urandom_range(1));
            mdu_wb_dest     = 5'($urandom_range(31));
            if (m_sb != 0 && $urandom_range(3) != 0) begin
                for (int k = 0; k < 64 && !m_sb[mdu_wb_dest]; k++)
                    mdu_wb_dest = 5'($urandom_range(31));
            end
            mdu_wb_wdata    = $urandom;
            mdu_wb_pc       = $urandom;
            mdu_issue_valid = ($urandom_range(4) < 2);
            mdu_issue_dest  = 5'($urandom_range(31));
            ds_rj           = 5'($urandom_range(31));
            ds_rk           = 5'($urandom_range(31));
            ds_rd           = 5'($urandom_range(31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
